// File: rtl/accelerator_mac_if.sv
// Register-bus bundle for the MAC accelerator: address/strobe/write data toward
// the peripheral and combinational read data back toward the CPU.
interface accelerator_mac_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/accelerator_mac.sv
// Multiply-accumulate engine on the byte-register peripheral bus: radix-2 shift-add
// multiply of A and B, result written to or accumulated into a guarded accumulator.
module accelerator_mac #(
  parameter int WIDTH = 16,
  parameter int GUARD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ui_in,
  output logic [7:0]       uo_out,
  accelerator_mac_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = PW + GUARD;
  localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [15:0]      a_r, b_r;
  logic             acc_mode_r, signed_r, ext_en_r;
  logic             done_r, ovf_r, ui_prev_r;
  logic [ACC_W-1:0] acc_r;
  logic [PW-1:0]    mcand_r, prod_r;
  logic [WIDTH-1:0] mplier_r;
  logic             neg_r, op_acc_mode_r, op_signed_r;
  logic [4:0]       cnt_r;

  logic             busy_s, wr_ctrl_s, wr_status_s;
  logic             wr_a_lo_s, wr_a_hi_s, wr_b_lo_s, wr_b_hi_s;
  logic             eff_signed_s, eff_acc_mode_s, ext_edge_s, start_s, clr_s;
  logic [WIDTH-1:0] a_op_s, b_op_s, a_mag_s, b_mag_s;
  logic             a_neg_s, b_neg_s;
  logic [PW-1:0]    p_signed_s;
  logic [ACC_W-1:0] p_ext_s;
  logic [ACC_W:0]   sum_s;
  logic             ovf_op_s;
  logic [47:0]      acc_ext_s;
  logic             unused_s;

  assign unused_s = &{ui_in[7:2], ui_in[0], 1'b0};

  // Bus decode and start/clear qualification; the mode bits written alongside START apply to that operation.
  always_comb begin
    busy_s         = (state_r != ST_IDLE);
    wr_ctrl_s      = bus.data_write && (bus.address == 4'h0);
    wr_status_s    = bus.data_write && (bus.address == 4'h1);
    wr_a_lo_s      = bus.data_write && (bus.address == 4'h2) && !busy_s;
    wr_a_hi_s      = bus.data_write && (bus.address == 4'h3) && !busy_s && (WIDTH == 16);
    wr_b_lo_s      = bus.data_write && (bus.address == 4'h4) && !busy_s;
    wr_b_hi_s      = bus.data_write && (bus.address == 4'h5) && !busy_s && (WIDTH == 16);
    eff_signed_s   = wr_ctrl_s ? bus.data_in[3] : signed_r;
    eff_acc_mode_s = wr_ctrl_s ? bus.data_in[1] : acc_mode_r;
    ext_edge_s     = ext_en_r && ui_in[1] && !ui_prev_r;
    start_s        = !busy_s && ((wr_ctrl_s && bus.data_in[0]) || ext_edge_s);
    clr_s          = !busy_s && wr_ctrl_s && bus.data_in[2];
  end

  // Operand magnitudes for the unsigned shift-add core; the sign is reapplied afterwards.
  always_comb begin
    a_op_s  = a_r[WIDTH-1:0];
    b_op_s  = b_r[WIDTH-1:0];
    a_neg_s = eff_signed_s && a_op_s[WIDTH-1];
    b_neg_s = eff_signed_s && b_op_s[WIDTH-1];
    a_mag_s = a_neg_s ? (-a_op_s) : a_op_s;
    b_mag_s = b_neg_s ? (-b_op_s) : b_op_s;
  end

  // Signed product, extension to accumulator width, sum and overflow detection.
  always_comb begin
    p_signed_s          = neg_r ? (-prod_r) : prod_r;
    p_ext_s             = {ACC_W{op_signed_r && p_signed_s[PW-1]}};
    p_ext_s[PW-1:0]     = p_signed_s;
    sum_s               = {1'b0, acc_r} + {1'b0, p_ext_s};
    if (op_signed_r) begin
      ovf_op_s = (acc_r[ACC_W-1] == p_ext_s[ACC_W-1]) && (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
    end else begin
      ovf_op_s = sum_s[ACC_W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: one MUL cycle per multiplier bit, then a single ACC write-back cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_MUL;
        else         state_s = ST_IDLE;
      end
      ST_MUL: begin
        if (cnt_r == LAST_CNT) state_s = ST_ACC;
        else                   state_s = ST_MUL;
      end
      ST_ACC:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Software-visible configuration and operand registers, plus the trigger edge detector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r        <= 16'h0000;
      b_r        <= 16'h0000;
      acc_mode_r <= 1'b0;
      signed_r   <= 1'b0;
      ext_en_r   <= 1'b0;
      ui_prev_r  <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        acc_mode_r <= bus.data_in[1];
        signed_r   <= bus.data_in[3];
        ext_en_r   <= bus.data_in[4];
      end
      if (wr_a_lo_s) a_r[7:0]  <= bus.data_in;
      if (wr_a_hi_s) a_r[15:8] <= bus.data_in;
      if (wr_b_lo_s) b_r[7:0]  <= bus.data_in;
      if (wr_b_hi_s) b_r[15:8] <= bus.data_in;
      ui_prev_r <= ui_in[1];
    end
  end

  // Multiply datapath: operands and modes latched at start, then one shift-add step per MUL cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r       <= '0;
      mplier_r      <= '0;
      prod_r        <= '0;
      cnt_r         <= 5'd0;
      neg_r         <= 1'b0;
      op_acc_mode_r <= 1'b0;
      op_signed_r   <= 1'b0;
    end else if (start_s) begin
      mcand_r       <= {{WIDTH{1'b0}}, a_mag_s};
      mplier_r      <= b_mag_s;
      prod_r        <= '0;
      cnt_r         <= 5'd0;
      neg_r         <= a_neg_s ^ b_neg_s;
      op_acc_mode_r <= eff_acc_mode_s;
      op_signed_r   <= eff_signed_s;
    end else if (state_r == ST_MUL) begin
      if (mplier_r[0]) prod_r <= prod_r + mcand_r;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + 5'd1;
    end
  end

  // Accumulator: cleared on request while idle, written back in the ACC state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clr_s) begin
      acc_r <= '0;
    end else if (state_r == ST_ACC) begin
      acc_r <= op_acc_mode_r ? sum_s[ACC_W-1:0] : p_ext_s;
    end
  end

  // Sticky status; a completion on the same edge as a STATUS write takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= (state_r == ST_ACC) || (done_r && !wr_status_s);
      ovf_r  <= ((state_r == ST_ACC) && op_acc_mode_r && ovf_op_s) || (ovf_r && !wr_status_s);
    end
  end

  // Read mux; accumulator bytes above ACC_W follow the current SIGNED setting.
  always_comb begin
    acc_ext_s            = {48{signed_r && acc_r[ACC_W-1]}};
    acc_ext_s[ACC_W-1:0] = acc_r;
    case (bus.address)
      4'h0:    bus.data_out = {3'b000, ext_en_r, signed_r, 1'b0, acc_mode_r, 1'b0};
      4'h1:    bus.data_out = {5'b00000, ovf_r, done_r, busy_s};
      4'h2:    bus.data_out = a_r[7:0];
      4'h3:    bus.data_out = a_r[15:8];
      4'h4:    bus.data_out = b_r[7:0];
      4'h5:    bus.data_out = b_r[15:8];
      4'h6:    bus.data_out = acc_ext_s[7:0];
      4'h7:    bus.data_out = acc_ext_s[15:8];
      4'h8:    bus.data_out = acc_ext_s[23:16];
      4'h9:    bus.data_out = acc_ext_s[31:24];
      4'hA:    bus.data_out = acc_ext_s[39:32];
      4'hB:    bus.data_out = acc_ext_s[47:40];
      default: bus.data_out = 8'h00;
    endcase
  end

  assign uo_out = {acc_r[4:0], done_r, busy_s, 1'b0};

endmodule
